// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the ALU iterative units.
// Holds the multiply-accumulate FSM state type and a helper that sizes
// the iteration counter from the operand width.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // Counter must hold 0..n-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// W-bit unsigned adder with carry in/out.
// Ports:
//   a, b   : W-bit addends
//   c_in   : carry in
//   sum    : W-bit sum
//   c_out  : carry out of the top bit
module full_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/seq_mult_add.sv
// Sequential shift-and-add multiply-accumulate: P = A*B + C in N cycles.
// Inverse datapath of the iterative divider (A=Q, B=divisor, C=R gives
// back the dividend); also used as a plain multiplier with C=0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load A/B/C and (re)start; aborts any running operation
//   A, B, C    : N-bit unsigned operands, sampled only on the start edge
//   busy       : high while iterating (exactly N cycles)
//   done       : one-cycle pulse when P/ovf are written
//   valid      : P/ovf hold a completed result (cleared by start/reset)
//   P          : 2N-bit result
//   ovf        : result does not fit in N bits
module seq_mult_add
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   C,
    output logic           busy,
    output logic           done,
    output logic           valid,
    output logic [2*N-1:0] P,
    output logic           ovf
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mul_state_t       state_q, state_d;
    logic [2*N-1:0]   mcand_q;
    logic [N-1:0]     mplier_q;
    logic [2*N-1:0]   acc_q;
    logic [CW-1:0]    cnt_q;

    logic [2*N-1:0]   addend;
    logic [2*N-1:0]   acc_next;
    logic             add_cout;
    logic             last;

    // Partial product for this iteration: shifted multiplicand gated by the
    // current multiplier LSB.
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign last   = (state_q == BUSY) && (cnt_q == LAST);

    full_adder #(.W(2*N)) u_acc_add (
        .a     (acc_q),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (acc_next),
        .c_out (add_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a start always wins, even on the completion edge.
    always_comb begin
        state_d = state_q;
        if (start)     state_d = BUSY;
        else if (last) state_d = IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q == BUSY);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            P        <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand_q  <= {{N{1'b0}}, A};
                mplier_q <= B;
                acc_q    <= {{N{1'b0}}, C};
                cnt_q    <= '0;
                valid    <= 1'b0;
            end else if (state_q == BUSY) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                if (last) begin
                    P     <= acc_next;
                    ovf   <= |acc_next[2*N-1:N];
                    done  <= 1'b1;
                    valid <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    // (2^N-1)^2 + 2^N-1 < 2^2N, so the accumulate can never carry out.
    always_ff @(posedge clk) begin
        if (!reset && state_q == BUSY)
            assert (add_cout == 1'b0);
    end

endmodule

// File: tb/tb_seq_mult_add.sv
module tb_seq_mult_add;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   A = '0, B = '0, C = '0;
    logic           busy, done, valid, ovf;
    logic [2*N-1:0] P;

    seq_mult_add #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .C(C),
        .busy(busy), .done(done), .valid(valid), .P(P), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint p;
        longint ovf;
        int     cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a negedge: start is sampled on the next posedge.
    // The expected result comes from the arithmetic definition, or from the
    // caller when a specific value (e.g. a dividend) must be reconstructed.
    task automatic issue(input int a, input int b, input int c, input longint exp_p);
        exp_t e;
        #1;
        A = N'(a); B = N'(b); C = N'(c);
        start = 1'b1;
        e.p   = exp_p;
        e.ovf = ((exp_p >> N) != 0) ? 1 : 0;
        e.cyc = cyc + 1 + N;
        exp_q.delete();          // any running operation is aborted
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        start = 1'b0;
        A = N'($urandom); B = N'($urandom); C = N'($urandom);
    endtask

    task automatic issue_mac(input int a, input int b, input int c);
        issue(a, b, c, longint'(a) * longint'(b) + longint'(c));
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < N + 5 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
        #1;
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("P", longint'(P), e.p);
                check("ovf", longint'(ovf), e.ovf);
                check("done_latency", cyc, e.cyc);
                check("valid_at_done", longint'(valid), 1);
                check("busy_at_done", longint'(busy), 0);
            end
        end
    end

    initial begin
        int nb, nd;
        longint hold_p;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", valid, 0);
        check("rst_P", longint'(P), 0);
        check("rst_ovf", ovf, 0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Basic: 13*11+2 = 145, with busy/done shape
        issue(13, 11, 2, 145);
        nb = busy; nd = done;
        repeat (N + 2) begin
            @(negedge clk);
            nb += busy; nd += done;
        end
        check("basic_busy_cycles", nb, N);
        check("basic_done_pulses", nd, 1);
        hold_p = longint'(P);
        repeat (3) @(negedge clk);
        check("basic_valid_hold", valid, 1);
        check("basic_P_hold", longint'(P), 145);
        check("basic_P_stable", longint'(P), hold_p);
        #1;

        // Max operands, then zero multiplier (still full latency)
        issue(255, 255, 255, 65280);
        wait_done();
        check("max_ovf", ovf, 1);
        issue(200, 0, 7, 7);
        check("valid_cleared_by_start", valid, 0);
        wait_done();
        check("zero_ovf", ovf, 0);

        // Divider round trip, back-to-back starts
        issue(200 / 7, 7, 200 % 7, 200);
        wait_done();
        for (int i = 0; i < 50; i++) begin
            int dividend, divisor;
            dividend = $urandom_range(0, 255);
            divisor  = $urandom_range(1, 255);
            issue(dividend / divisor, divisor, dividend % divisor, dividend);
            wait_done();
        end

        // Random general multiply-accumulate
        for (int i = 0; i < 20; i++) begin
            issue_mac($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            wait_done();
        end

        // Restart mid-operation: only the second operation completes
        issue(3, 5, 0, 15);
        repeat (2) @(negedge clk);
        issue(9, 9, 1, 82);
        nd = done;
        repeat (N + 4) begin
            @(negedge clk);
            nd += done;
        end
        check("restart_done_pulses", nd, 1);
        check("restart_P", longint'(P), 82);
        #1;

        // Reset mid-operation: outputs clear, no done
        issue(77, 99, 5, 7628);
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_P", longint'(P), 0);
        check("midrst_done", done, 0);
        #1 reset = 1'b0;
        nd = 0;
        repeat (N + 4) begin
            @(negedge clk);
            nd += done;
        end
        check("midrst_no_done", nd, 0);
        check("midrst_idle_busy", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
